isa_burst_reader: RTL and testbench
===================================

# isa_burst_reader

Upstream feeder of the instruction cache. Accepts the cache's ISA load request (`ISA_read_req`/`ISA_read_addr`/`isa_read_len`), splits it into DDR read bursts of at most `FIFO_DEPTH` beats, and buffers returned beats in a small FIFO. Each beat is replayed to the cache as one ISA word with a running count, paced so that every word and count stay stable for at least two cycles. It sits between the DDR burst controller and the instruction cache.

## Interface
- `DDR_ADDR_WIDTH`, 28, DDR byte address width
- `DDR_DATA_WIDTH`, 64, DDR beat width; one beat carries one instruction
- `ISA_WIDTH`, 30, instruction width (4+8+2+16); word = `ddr_rd_data[ISA_WIDTH-1:0]`
- `FIFO_DEPTH`, 4, beat buffer depth and maximum sub-burst length (power of 2, ≥2)
- `BEAT_BYTES`, 8, address increment per beat
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset synchronous, active-high
- `ISA_read_req`  in  1  level request from cache
- `ISA_read_addr`  in  DDR_ADDR_WIDTH  start byte address
- `isa_read_len`  in  10  words to fetch
- `instruction_to_cache`  out  ISA_WIDTH  current word
- `rd_cnt_isa`  out  10  words delivered since accept
- `rd_burst_data_valid`  out  1  one-cycle pulse per delivered word
- `ddr_rd_req`  out  1  burst request, held until `ddr_rd_finish`
- `ddr_rd_addr`  out  DDR_ADDR_WIDTH  burst start address
- `ddr_rd_len`  out  10  burst beats
- `ddr_rd_data`  in  DDR_DATA_WIDTH  returned beat
- `ddr_rd_data_valid`  in  1  beat strobe (no backpressure)
- `ddr_rd_finish`  in  1  one-cycle end-of-burst pulse
- `st_cur_isa_rd`  out  3  current state, for debug
- `err_overflow`  out  1  sticky error flag (see Configuration)

## Operation
- States: IDLE=0, ISSUE=1, WAIT_ROOM=2, DONE=3, ABORT=4.
- IDLE:
  - If `ISA_read_req`=1 and `isa_read_len`≠0: latch addr and len, clear `rd_cnt_isa`, set issued=0, go to ISSUE.
  - If `isa_read_len`=0: the request is ignored and the block stays in IDLE.
- ISSUE:
  - `ddr_rd_req`=1, `ddr_rd_len`=min(len−issued, FIFO_DEPTH), `ddr_rd_addr`=base+issued·BEAT_BYTES.
  - On `ddr_rd_finish`: issued += `ddr_rd_len`. If issued=len go to DONE; else go to WAIT_ROOM.
  - If `ISA_read_req` drops during ISSUE, go to ABORT.
- WAIT_ROOM: when the FIFO is empty, go to ISSUE. If req drops, go to IDLE (FIFO flushed).
- DONE: all beats fetched, and the emitter keeps delivering. When `ISA_read_req`=0, go to IDLE. `rd_cnt_isa` holds its value until the next accept.
- ABORT: `ddr_rd_req` stays high until `ddr_rd_finish`; beats are discarded. Then flush the FIFO and go to IDLE.
- FIFO and emitter:
  - Every `ddr_rd_data_valid` in ISSUE writes the FIFO. Beats are dropped in all other states.
  - Emitter runs when the FIFO is non-empty and the previous pulse is ≥2 cycles old. It pops a word, registers `instruction_to_cache`, increments `rd_cnt_isa`, and pulses `rd_burst_data_valid`.
  - Data and count hold until the next pulse.
- No `rd_burst_data_valid` pulse occurs in IDLE or ABORT.
- Arithmetic:
  - issued and count are 10-bit. `len` ≤ 1023; no wrap.
  - Address add is modulo 2^DDR_ADDR_WIDTH.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, `err_overflow`=0.
- Reset mid-burst: `ddr_rd_req` drops the next cycle; late beats arrive in IDLE and are ignored.
- `ddr_rd_req` rises 1 cycle after accept. Re-issue from WAIT_ROOM occurs 1 cycle after the FIFO is empty.
- A beat written at cycle t is emitted at t+2 at the earliest (FIFO write, then pop and register).
- Pulse spacing is ≥2 cycles: pulse, gap, pulse. Back-to-back DDR beats are absorbed by the FIFO, which is sized to one full sub-burst.
- Simultaneous FIFO write and pop in one cycle is legal; occupancy is unchanged.
- Simultaneous `ddr_rd_finish` and req drop is treated as a finish. The remaining chunk is not issued, and the state goes to IDLE on the next cycle.

## Configuration
- `ISA_RD_OVERFLOW_CHK_EN` defined: `err_overflow` sets (sticky until `rst`) on either of:
  - a beat arriving with the FIFO full;
  - more than `ddr_rd_len` beats arriving in one burst.
- `ISA_RD_OVERFLOW_CHK_EN` undefined: `err_overflow` is tied 0 and the checking logic is absent.

## Test plan
- len=3, addr=0x40: one burst (len 3, addr 0x40). Three pulses with `rd_cnt_isa` 1,2,3 and words equal to the beat low 30 bits. State goes to DONE; after req drops, IDLE.
- len=10, FIFO_DEPTH=4, back-to-back beats: bursts (0x00,4), (0x20,4), (0x40,2). 10 pulses, each ≥2 cycles apart; final `rd_cnt_isa`=10.
- Req dropped mid-ISSUE after 2 beats of a 4-beat burst: `ddr_rd_req` held until finish, then IDLE. No pulses after the drop.
- `rst` asserted during ISSUE with beats still arriving: outputs 0 next cycle, no pulses, FIFO empty. A subsequent len=1 request works normally.
- With `ISA_RD_OVERFLOW_CHK_EN`: model sends 5 beats for `ddr_rd_len`=4. `err_overflow`=1 and stays 1 until `rst`.
- len=0 with req high: no `ddr_rd_req` and the state stays IDLE.

Source files
------------

// File: rtl/isa_burst_reader.sv
// isa_burst_reader: takes one ISA load request from the instruction cache,
// splits it into DDR read bursts of at most FIFO_DEPTH beats, buffers the
// returned beats and replays each beat to the cache as one ISA word. Every
// word/count pair stays stable for at least two cycles.
// Optional build macro: ISA_RD_OVERFLOW_CHK_EN enables the sticky
// err_overflow detector; without it err_overflow is tied low.
//
// DDR handshake: ddr_rd_req is a level request held from the issue cycle until
// the cycle after ddr_rd_finish is sampled high; ddr_rd_addr/ddr_rd_len are
// stable for the whole time ddr_rd_req is high. ddr_rd_data is taken on every
// cycle ddr_rd_data_valid is high (there is no backpressure). ddr_rd_finish is
// a single-cycle pulse that closes the current burst.
module isa_burst_reader #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DDR_DATA_WIDTH = 64,
    parameter int ISA_WIDTH      = 30,
    parameter int FIFO_DEPTH     = 4,
    parameter int BEAT_BYTES     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ISA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    input  logic [9:0]                isa_read_len,
    output logic [ISA_WIDTH-1:0]      instruction_to_cache,
    output logic [9:0]                rd_cnt_isa,
    output logic                      rd_burst_data_valid,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    output logic [9:0]                ddr_rd_len,
    input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
    input  logic                      ddr_rd_data_valid,
    input  logic                      ddr_rd_finish,
    output logic [2:0]                st_cur_isa_rd,
    output logic                      err_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [9:0]     DEPTH10  = 10'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ROOM = 3'd2,
        ST_DONE      = 3'd3,
        ST_ABORT     = 3'd4
    } state_t;

    state_t                    state_q;
    logic [DDR_ADDR_WIDTH-1:0] base_q;
    logic [9:0]                len_q;
    logic [9:0]                issued_q;

    logic                      req_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [9:0]                rlen_q;
    logic [ISA_WIDTH-1:0]      word_q;
    logic [9:0]                cnt_q;
    logic                      valid_q;

    logic [ISA_WIDTH-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]            wr_ptr_q;
    logic [PTR_W:0]            rd_ptr_q;

    logic [PTR_W:0]            fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      beat_wr;
    logic                      emit_live;
    logic                      pop;
    logic [9:0]                issued_nxt;
    logic [9:0]                next_chunk;
    logic [DDR_ADDR_WIDTH-1:0] next_addr;
    logic                      unused_upper;

    function automatic logic [9:0] chunk_of(input logic [9:0] n);
        return (n > DEPTH10) ? DEPTH10 : n;
    endfunction

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_count == FULL_CNT);

    // Beats are only accepted while a live burst is being fetched.
    assign beat_wr = ddr_rd_data_valid && (state_q == ST_ISSUE) && !fifo_full;

    // The pulse is registered, so a pop is only allowed when the state the
    // pulse will be visible in is one that may deliver words.
    always_comb begin
        emit_live = 1'b0;
        case (state_q)
            ST_ISSUE:              emit_live = ISA_read_req | ddr_rd_finish;
            ST_WAIT_ROOM, ST_DONE: emit_live = ISA_read_req;
            default:               emit_live = 1'b0;
        endcase
    end

    // Keep a one-cycle gap after every pulse.
    assign pop = emit_live && !fifo_empty && !valid_q;

    assign issued_nxt = issued_q + rlen_q;
    assign next_chunk = chunk_of(len_q - issued_q);
    assign next_addr  = base_q + (DDR_ADDR_WIDTH'(issued_q) * DDR_ADDR_WIDTH'(BEAT_BYTES));

    assign unused_upper = ^ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];

    // Beat storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= ddr_rd_data[ISA_WIDTH-1:0];
        end
    end

    // Control FSM together with FIFO pointers, emitter and DDR request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            rlen_q   <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                word_q   <= fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
                cnt_q    <= cnt_q + 10'd1;
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (beat_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    // Keep the buffer empty so no stale beat survives a request.
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    if (ISA_read_req && (isa_read_len != 10'd0)) begin
                        base_q   <= ISA_read_addr;
                        len_q    <= isa_read_len;
                        issued_q <= '0;
                        cnt_q    <= '0;
                        req_q    <= 1'b1;
                        addr_q   <= ISA_read_addr;
                        rlen_q   <= chunk_of(isa_read_len);
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A finish wins over a simultaneous request drop.
                    if (ddr_rd_finish) begin
                        req_q    <= 1'b0;
                        issued_q <= issued_nxt;
                        state_q  <= (issued_nxt == len_q) ? ST_DONE : ST_WAIT_ROOM;
                    end else if (!ISA_read_req) begin
                        state_q <= ST_ABORT;
                    end
                end
                ST_WAIT_ROOM: begin
                    if (!ISA_read_req) begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        state_q  <= ST_IDLE;
                    end else if (fifo_empty) begin
                        req_q   <= 1'b1;
                        addr_q  <= next_addr;
                        rlen_q  <= next_chunk;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    if (!ISA_read_req) begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    // The DDR side must see its burst closed before we let go.
                    if (ddr_rd_finish) begin
                        req_q    <= 1'b0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ISA_RD_OVERFLOW_CHK_EN
    logic [9:0] beat_cnt_q;
    logic       err_q;

    // Sticky detector for beats the buffer or the burst length cannot account for.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (!req_q) begin
                beat_cnt_q <= '0;
            end else if (ddr_rd_data_valid && (state_q == ST_ISSUE)) begin
                beat_cnt_q <= beat_cnt_q + 10'd1;
            end
            if (ddr_rd_data_valid && (state_q == ST_ISSUE) &&
                (fifo_full || (beat_cnt_q >= rlen_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_overflow = err_q;
`else
    assign err_overflow = 1'b0;
`endif

    assign instruction_to_cache = word_q;
    assign rd_cnt_isa           = cnt_q;
    assign rd_burst_data_valid  = valid_q;
    assign ddr_rd_req           = req_q;
    assign ddr_rd_addr          = addr_q;
    assign ddr_rd_len           = rlen_q;
    assign st_cur_isa_rd        = state_q;

endmodule

// File: tb/tb_isa_burst_reader.sv
// Bench for isa_burst_reader: a DDR responder returns random beats for every
// burst the block requests, a monitor records every delivered word, and each
// scenario task compares the recording with a reference built from the
// request (burst split list, beat sequence, counts and pulse spacing).
module tb_isa_burst_reader;

    logic        clk;
    logic        rst;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic [29:0] instruction_to_cache;
    logic [9:0]  rd_cnt_isa;
    logic        rd_burst_data_valid;
    logic        ddr_rd_req;
    logic [27:0] ddr_rd_addr;
    logic [9:0]  ddr_rd_len;
    logic [63:0] ddr_rd_data;
    logic        ddr_rd_data_valid;
    logic        ddr_rd_finish;
    logic [2:0]  st_cur_isa_rd;
    logic        err_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Responder knobs and records
    bit          gap_mode = 0;
    int          extra_beats = 0;
    bit          resp_busy;
    int          beats_sent = 0;
    logic [29:0] exp_q[$];
    int          beat_cyc_q[$];
    logic [27:0] obs_baddr_q[$];
    logic [9:0]  obs_blen_q[$];

    // Monitor records
    logic [29:0] obs_word_q[$];
    logic [9:0]  obs_cnt_q[$];
    int          obs_cyc_q[$];
    int          bad_pulses = 0;

    isa_burst_reader dut (
        .clk                  (clk),
        .rst                  (rst),
        .ISA_read_req         (ISA_read_req),
        .ISA_read_addr        (ISA_read_addr),
        .isa_read_len         (isa_read_len),
        .instruction_to_cache (instruction_to_cache),
        .rd_cnt_isa           (rd_cnt_isa),
        .rd_burst_data_valid  (rd_burst_data_valid),
        .ddr_rd_req           (ddr_rd_req),
        .ddr_rd_addr          (ddr_rd_addr),
        .ddr_rd_len           (ddr_rd_len),
        .ddr_rd_data          (ddr_rd_data),
        .ddr_rd_data_valid    (ddr_rd_data_valid),
        .ddr_rd_finish        (ddr_rd_finish),
        .st_cur_isa_rd        (st_cur_isa_rd),
        .err_overflow         (err_overflow)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DDR responder: one burst per request, beats then a finish pulse
    initial begin : ddr_model
        int nbeats;
        int gap;
        ddr_rd_data_valid = 1'b0;
        ddr_rd_finish     = 1'b0;
        ddr_rd_data       = '0;
        resp_busy         = 1'b0;
        forever begin
            @(negedge clk);
            if (ddr_rd_req === 1'b1) begin
                resp_busy = 1'b1;
                obs_baddr_q.push_back(ddr_rd_addr);
                obs_blen_q.push_back(ddr_rd_len);
                nbeats = int'(ddr_rd_len) + extra_beats;
                for (int b = 0; b < nbeats; b++) begin
                    @(posedge clk); #1;
                    if (gap_mode) begin
                        gap = $urandom_range(0, 2);
                        ddr_rd_data_valid = 1'b0;
                        repeat (gap) begin
                            @(posedge clk); #1;
                        end
                    end
                    ddr_rd_data       = {$urandom(), $urandom()};
                    ddr_rd_data_valid = 1'b1;
                    exp_q.push_back(ddr_rd_data[29:0]);
                    beat_cyc_q.push_back(cyc);
                    beats_sent++;
                end
                @(posedge clk); #1;
                ddr_rd_data_valid = 1'b0;
                ddr_rd_finish     = 1'b1;
                @(posedge clk); #1;
                ddr_rd_finish = 1'b0;
                resp_busy     = 1'b0;
            end
        end
    end

    // Monitor of delivered words
    always @(negedge clk) begin
        if (!rst && rd_burst_data_valid === 1'b1) begin
            obs_word_q.push_back(instruction_to_cache);
            obs_cnt_q.push_back(rd_cnt_isa);
            obs_cyc_q.push_back(cyc);
            if (st_cur_isa_rd == 3'd0 || st_cur_isa_rd == 3'd4) bad_pulses++;
        end
    end

    task automatic wait_resp_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!resp_busy) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_resp_idle: responder still busy after 200 cycles, required idle", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ISA_read_req = 1'b0;
        ISA_read_addr = '0;
        isa_read_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ddr_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", ddr_rd_req); end
        checks++; if (ddr_rd_addr !== 28'd0) begin errors++; $display("FAIL reset_addr: got %0h, required 0", ddr_rd_addr); end
        checks++; if (ddr_rd_len !== 10'd0) begin errors++; $display("FAIL reset_len: got %0d, required 0", ddr_rd_len); end
        checks++; if (rd_burst_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", rd_burst_data_valid); end
        checks++; if (rd_cnt_isa !== 10'd0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", rd_cnt_isa); end
        checks++; if (instruction_to_cache !== 30'd0) begin errors++; $display("FAIL reset_word: got %0h, required 0", instruction_to_cache); end
        checks++; if (st_cur_isa_rd !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", st_cur_isa_rd); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_overflow); end
    endtask

    // One complete request, checked against the burst split and beat stream
    task automatic run_request(input logic [27:0] addr, input logic [9:0] len,
                               input bit gaps, input string name);
        int          w0, e0, b0, bad0, issued, chunk, n;
        bit          ok;
        logic [27:0] m_addr[$];
        logic [9:0]  m_len[$];
        w0 = obs_word_q.size();
        e0 = exp_q.size();
        b0 = obs_baddr_q.size();
        bad0 = bad_pulses;
        gap_mode = gaps;
        @(posedge clk); #1;
        ISA_read_addr = addr;
        isa_read_len  = len;
        ISA_read_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ddr_rd_req !== 1'b1) begin errors++; $display("FAIL %s_req_rise: got %b, required 1", name, ddr_rd_req); end

        ok = 0;
        for (int i = 0; i < int'(len) * 24 + 100; i++) begin
            @(negedge clk);
            if (obs_word_q.size() - w0 >= int'(len)) begin
                ok = 1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got %0d words, required %0d", name, obs_word_q.size() - w0, len); end
        repeat (4) @(negedge clk);

        issued = 0;
        while (issued < int'(len)) begin
            chunk = (int'(len) - issued > 4) ? 4 : int'(len) - issued;
            m_addr.push_back(addr + 28'(issued * 8));
            m_len.push_back(10'(chunk));
            issued += chunk;
        end
        checks++; if (obs_baddr_q.size() - b0 != m_addr.size()) begin errors++; $display("FAIL %s_burst_count: got %0d, required %0d", name, obs_baddr_q.size() - b0, m_addr.size()); end
        n = (obs_baddr_q.size() - b0 < m_addr.size()) ? obs_baddr_q.size() - b0 : m_addr.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (obs_baddr_q[b0+i] !== m_addr[i]) begin errors++; $display("FAIL %s_burst_addr[%0d]: got %0h, required %0h", name, i, obs_baddr_q[b0+i], m_addr[i]); end
            checks++; if (obs_blen_q[b0+i] !== m_len[i]) begin errors++; $display("FAIL %s_burst_len[%0d]: got %0d, required %0d", name, i, obs_blen_q[b0+i], m_len[i]); end
        end

        checks++; if (obs_word_q.size() - w0 != int'(len)) begin errors++; $display("FAIL %s_pulse_count: got %0d, required %0d", name, obs_word_q.size() - w0, len); end
        n = obs_word_q.size() - w0;
        if (exp_q.size() - e0 < n) n = exp_q.size() - e0;
        if (int'(len) < n) n = int'(len);
        for (int i = 0; i < n; i++) begin
            checks++; if (obs_word_q[w0+i] !== exp_q[e0+i]) begin errors++; $display("FAIL %s_word[%0d]: got %0h, required %0h", name, i, obs_word_q[w0+i], exp_q[e0+i]); end
            checks++; if (obs_cnt_q[w0+i] !== 10'(i + 1)) begin errors++; $display("FAIL %s_cnt[%0d]: got %0d, required %0d", name, i, obs_cnt_q[w0+i], i + 1); end
            if (i > 0) begin
                checks++; if (obs_cyc_q[w0+i] - obs_cyc_q[w0+i-1] < 2) begin errors++; $display("FAIL %s_spacing[%0d]: got %0d cycles, required >=2", name, i, obs_cyc_q[w0+i] - obs_cyc_q[w0+i-1]); end
            end
        end
        if (n > 0) begin
            checks++; if (obs_cyc_q[w0] !== beat_cyc_q[e0] + 2) begin errors++; $display("FAIL %s_first_latency: got cycle %0d, required %0d", name, obs_cyc_q[w0], beat_cyc_q[e0] + 2); end
        end
        checks++; if (st_cur_isa_rd !== 3'd3) begin errors++; $display("FAIL %s_done_state: got %0d, required 3", name, st_cur_isa_rd); end

        @(posedge clk); #1;
        ISA_read_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (st_cur_isa_rd !== 3'd0) begin errors++; $display("FAIL %s_idle_state: got %0d, required 0", name, st_cur_isa_rd); end
        checks++; if (rd_cnt_isa !== len) begin errors++; $display("FAIL %s_cnt_hold: got %0d, required %0d", name, rd_cnt_isa, len); end
        checks++; if (ddr_rd_req !== 1'b0) begin errors++; $display("FAIL %s_req_low: got %b, required 0", name, ddr_rd_req); end
        checks++; if (bad_pulses !== bad0) begin errors++; $display("FAIL %s_illegal_pulse: got %0d pulses in IDLE/ABORT, required 0", name, bad_pulses - bad0); end
        wait_resp_idle(name);
    endtask

    task automatic test_single();
        run_request(28'h40, 10'd3, 1'b0, "single");
    endtask

    task automatic test_back_to_back();
        run_request(28'h0, 10'd10, 1'b0, "b2b");
    endtask

    task automatic test_random();
        logic [27:0] a;
        logic [9:0]  l;
        for (int k = 0; k < 3; k++) begin
            a = 28'($urandom());
            l = 10'($urandom_range(1, 20));
            run_request(a, l, 1'b1, "random");
        end
        run_request(28'hFFFFFF0, 10'd5, 1'b1, "wrap");
    endtask

    task automatic test_abort();
        int  w0, s0, d, late;
        bit  ok, fell;
        w0 = obs_word_q.size();
        s0 = beats_sent;
        gap_mode = 0;
        @(posedge clk); #1;
        ISA_read_addr = 28'h100;
        isa_read_len  = 10'd8;
        ISA_read_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beats_sent - s0 >= 2) begin
                ok = 1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_beats_timeout: got %0d beats, required 2", beats_sent - s0); end
        @(posedge clk); #1;
        ISA_read_req = 1'b0;
        d = cyc;
        @(negedge clk);
        fell = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ddr_rd_req === 1'b1) begin
                checks++; if (st_cur_isa_rd !== 3'd4) begin errors++; $display("FAIL abort_state: got %0d, required 4", st_cur_isa_rd); end
            end else begin
                fell = 1;
                break;
            end
        end
        checks++; if (!fell) begin errors++; $display("FAIL abort_req_release: req still %b after 40 cycles, required 0", ddr_rd_req); end
        checks++; if (beats_sent - s0 != 4) begin errors++; $display("FAIL abort_req_held: req dropped after %0d beats, required 4", beats_sent - s0); end
        checks++; if (st_cur_isa_rd !== 3'd0) begin errors++; $display("FAIL abort_idle: got %0d, required 0", st_cur_isa_rd); end
        repeat (10) @(negedge clk);
        late = 0;
        for (int i = w0; i < obs_cyc_q.size(); i++) if (obs_cyc_q[i] > d) late++;
        checks++; if (late != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d pulses after drop, required 0", late); end
        checks++; if (ddr_rd_req !== 1'b0) begin errors++; $display("FAIL abort_req_stays_low: got %b, required 0", ddr_rd_req); end
        wait_resp_idle("abort");
    endtask

    task automatic test_reset_mid();
        int  w0, s0, r, late;
        bit  ok;
        w0 = obs_word_q.size();
        s0 = beats_sent;
        gap_mode = 0;
        @(posedge clk); #1;
        ISA_read_addr = 28'h300;
        isa_read_len  = 10'd8;
        ISA_read_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beats_sent - s0 >= 2) begin
                ok = 1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_beats_timeout: got %0d beats, required 2", beats_sent - s0); end
        @(posedge clk); #1;
        rst = 1'b1;
        ISA_read_req = 1'b0;
        r = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ddr_rd_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b, required 0", ddr_rd_req); end
        checks++; if (rd_cnt_isa !== 10'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d, required 0", rd_cnt_isa); end
        checks++; if (instruction_to_cache !== 30'd0) begin errors++; $display("FAIL rstmid_word: got %0h, required 0", instruction_to_cache); end
        checks++; if (rd_burst_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", rd_burst_data_valid); end
        checks++; if (ddr_rd_len !== 10'd0) begin errors++; $display("FAIL rstmid_len: got %0d, required 0", ddr_rd_len); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (ddr_rd_req !== 1'b0 || st_cur_isa_rd !== 3'd0) begin errors++; $display("FAIL rstmid_idle: req %b state %0d, required 0/0", ddr_rd_req, st_cur_isa_rd); end
        end
        late = 0;
        for (int i = w0; i < obs_cyc_q.size(); i++) if (obs_cyc_q[i] > r) late++;
        checks++; if (late != 0) begin errors++; $display("FAIL rstmid_no_pulse: got %0d pulses after reset, required 0", late); end
        wait_resp_idle("rstmid");
        run_request(28'h200, 10'd1, 1'b0, "rst_then_len1");
    endtask

    task automatic test_len_zero();
        int b0;
        b0 = obs_baddr_q.size();
        @(posedge clk); #1;
        ISA_read_addr = 28'h80;
        isa_read_len  = 10'd0;
        ISA_read_req  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (ddr_rd_req !== 1'b0 || st_cur_isa_rd !== 3'd0) begin errors++; $display("FAIL len0_idle: req %b state %0d, required 0/0", ddr_rd_req, st_cur_isa_rd); end
        end
        checks++; if (obs_baddr_q.size() != b0) begin errors++; $display("FAIL len0_bursts: got %0d bursts, required 0", obs_baddr_q.size() - b0); end
        @(posedge clk); #1;
        ISA_read_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
`ifdef ISA_RD_OVERFLOW_CHK_EN
        int  s0;
        bit  ok;
        s0 = beats_sent;
        gap_mode = 0;
        extra_beats = 1;
        @(posedge clk); #1;
        ISA_read_addr = 28'h500;
        isa_read_len  = 10'd4;
        ISA_read_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (beats_sent - s0 >= 5 && !resp_busy) begin
                ok = 1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got %0d beats, required 5", beats_sent - s0); end
        extra_beats = 0;
        repeat (12) @(negedge clk);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", err_overflow); end
        @(posedge clk); #1;
        ISA_read_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", err_overflow); end
        checks++; if (st_cur_isa_rd !== 3'd0) begin errors++; $display("FAIL ovf_idle: got %0d, required 0", st_cur_isa_rd); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", err_overflow); end
`else
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_tied: got %b, required 0", err_overflow); end
`endif
    endtask

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_len_zero();
        test_abort();
        test_reset_mid();
        test_random();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
